serial_sub_ctrl: RTL and testbench
==================================

Name: serial_sub_ctrl

Overview:
Bit-serial multi-bit subtractor controller. It sequences a single full-subtractor cell, one bit per clock from LSB to MSB, and keeps the borrow in a register between bits. It computes diff = a - b - bin over WIDTH bits under a start/busy/done handshake. It sits between a requesting block and the subtractor cell, so one cell serves any operand width.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)
CW, $clog2(WIDTH+1), bit-counter width

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when idle or done
a  input  WIDTH  minuend; captured on the accepted start edge
b  input  WIDTH  subtrahend; captured on the accepted start edge
bin  input  1  initial borrow-in; captured on the accepted start edge
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse; result valid
diff  output  WIDTH  registered difference, held until next completion
bout  output  1  final borrow-out (1 = a < b + bin, unsigned)
zero  output  1  high when diff == 0; held with diff

Behaviour:
- Reset (rst=1 at any edge, including mid-operation):
  - State goes to IDLE.
  - busy=0, done=0, diff=0, bout=0, zero=0.
  - Counter, shift registers and borrow register are cleared.
  - No partial result is ever published.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 → RUN.
  - At that edge, load the a/b shift registers, set borrow register = bin, counter = 0.
- RUN: each edge runs one full-subtractor step on the LSBs a0, b0 and borrow br:
  - d = a0^b0^br
  - br_next = (~a0&b0) | (~(a0^b0)&br)
  - d is shifted into the working result register from the MSB side.
  - a/b shift right; counter increments.
- After WIDTH RUN edges (E1..E_WIDTH) → DONE.
  - On the final edge, diff ← completed working result, bout ← final borrow, zero ← (result == 0).
- DONE lasts exactly one cycle, with done=1.
  - start=1 at the edge leaving DONE → RUN (back-to-back), same load actions as IDLE.
  - Otherwise → IDLE.
- busy=1 exactly while in RUN, i.e. from edge E0 to edge E_WIDTH (WIDTH cycles).
- done rises at edge E_WIDTH, falls at E_WIDTH+1. Latency: start-sample edge to done = WIDTH edges. Throughput: one result per WIDTH+1 cycles.
- diff/bout/zero change only on the final RUN edge or on reset; they are stable at all other times, including during a subsequent operation.
- start while busy is ignored; it is not queued and does not alter in-flight operands.
- a/b/bin changing after the accepted start edge have no effect on the current operation.
- Arithmetic is unsigned modulo 2^WIDTH.
  - Underflow wraps, with bout=1.
  - Result = (a - b - bin) mod 2^WIDTH.
- rst and start asserted together: reset wins.

Test Plan:
1. WIDTH=8, a=0x05, b=0x03, bin=0, start 1 cycle → busy for 8 cycles, done pulse 8 edges after start edge, diff=0x02, bout=0, zero=0.
2. a=0x03, b=0x05, bin=0 → diff=0xFE, bout=1, zero=0. Then a=0x00, b=0x00, bin=1 → diff=0xFF, bout=1.
3. a=0x80, b=0x80, bin=0 → diff=0x00, bout=0, zero=1. Previous diff stays held throughout busy until done.
4. Start a=0x10, b=0x01; at 3 cycles in, pulse start with a=0xFF, b=0x00 and change a/b → second start ignored, done once, diff=0x0F.
5. Assert rst at bit 4 of an operation → next cycle busy=0, done=0, diff=0, bout=0, zero=0. Then a fresh start a=0x09, b=0x04 → diff=0x05, correct timing.
6. Hold start=1 continuously with a=0x20, b=0x10, then a=0x01, b=0x02 presented during the done cycle → results 0x10/bout=0 then 0xFF/bout=1. Done pulses 9 cycles apart, with no idle cycle between.

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl
// Bit-serial subtractor controller. One full-subtractor step is applied per
// clock, LSB first, with the borrow carried in a register between bits.
// The controller computes diff = (a - b - bin) mod 2^WIDTH under a
// start/busy/done handshake.
//
// Ports:
//   clk   - system clock, all state changes on the rising edge
//   rst   - synchronous active-high reset
//   start - request, sampled only in IDLE or DONE
//   a, b  - minuend / subtrahend, captured on the accepted start edge
//   bin   - initial borrow-in, captured on the accepted start edge
//   busy  - high while bits are being processed (WIDTH cycles)
//   done  - one-cycle pulse when a new result is published
//   diff  - registered difference, held until the next completion
//   bout  - final borrow-out (1 when a < b + bin, unsigned)
//   zero  - high when diff == 0, held with diff
module serial_sub_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // One full-subtractor cell: returns {borrow_out, difference_bit}.
  function automatic logic [1:0] fsub(input logic x, input logic y, input logic bi);
    fsub = {(~x & y) | (~(x ^ y) & bi), x ^ y ^ bi};
  endfunction

  logic [1:0]       state_r, state_s;
  logic [WIDTH-1:0] a_sh_r, a_sh_s;
  logic [WIDTH-1:0] b_sh_r, b_sh_s;
  logic [WIDTH-1:0] res_r, res_s;
  logic             br_r, br_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [WIDTH-1:0] diff_r, diff_s;
  logic             bout_r, bout_s;
  logic             zero_r, zero_s;

  logic [1:0]       step_s;
  logic [WIDTH-1:0] res_step_s;

  // Current bit step: the new difference bit enters the result from the MSB
  // side so that after WIDTH shifts the first (LSB) bit has reached bit 0.
  always_comb begin
    step_s     = fsub(a_sh_r[0], b_sh_r[0], br_r);
    res_step_s = {step_s[0], res_r[WIDTH-1:1]};
  end

  // Next-state and datapath decode for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_s = state_r;
    a_sh_s  = a_sh_r;
    b_sh_s  = b_sh_r;
    res_s   = res_r;
    br_s    = br_r;
    cnt_s   = cnt_r;
    busy_s  = 1'b0;
    done_s  = 1'b0;
    diff_s  = diff_r;
    bout_s  = bout_r;
    zero_s  = zero_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s = RUN;
          a_sh_s  = a;
          b_sh_s  = b;
          res_s   = {WIDTH{1'b0}};
          br_s    = bin;
          cnt_s   = {CW{1'b0}};
          busy_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        a_sh_s = {1'b0, a_sh_r[WIDTH-1:1]};
        b_sh_s = {1'b0, b_sh_r[WIDTH-1:1]};
        res_s  = res_step_s;
        br_s   = step_s[1];
        cnt_s  = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_r == CW'(WIDTH-1)) begin
          // Final bit: publish the whole result at once, never a partial one.
          state_s = DONE;
          done_s  = 1'b1;
          diff_s  = res_step_s;
          bout_s  = step_s[1];
          zero_s  = (res_step_s == {WIDTH{1'b0}});
        end else begin
          busy_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        a_sh_s  = {WIDTH{1'b0}};
        b_sh_s  = {WIDTH{1'b0}};
        res_s   = {WIDTH{1'b0}};
        br_s    = 1'b0;
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      br_r    <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      diff_r  <= {WIDTH{1'b0}};
      bout_r  <= 1'b0;
      zero_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      a_sh_r  <= a_sh_s;
      b_sh_r  <= b_sh_s;
      res_r   <= res_s;
      br_r    <= br_s;
      cnt_r   <= cnt_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      diff_r  <= diff_s;
      bout_r  <= bout_s;
      zero_r  <= zero_s;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign diff = diff_r;
  assign bout = bout_r;
  assign zero = zero_r;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Testbench for serial_sub_ctrl (WIDTH=8). Directed operations push their
// hand-computed results into a scoreboard queue together with the cycle on
// which done must appear; a monitor pops and compares on every done pulse.
module tb_serial_sub_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;
  logic       zero;

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    logic       zero;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  serial_sub_ctrl #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .diff (diff),
    .bout (bout),
    .zero (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges so done timing can be checked against the schedule.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared = compared + 1;
    if (act !== exp) begin
      mismatched = mismatched + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("diff", {24'd0, diff}, {24'd0, e.diff});
        check("bout", {31'd0, bout}, {31'd0, e.bout});
        check("zero", {31'd0, zero}, {31'd0, e.zero});
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Present a one-cycle start at a negedge and schedule its result.
  task automatic issue(input logic [7:0] va, input logic [7:0] vb, input logic vbin,
                       input logic [7:0] ed, input logic eb, input logic ez);
    exp_t e;
    a = va; b = vb; bin = vbin; start = 1'b1;
    e.diff = ed; e.bout = eb; e.zero = ez; e.cyc = cyc + 1 + 8;
    q.push_back(e);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    check("drain_timeout", q.size(), 32'd0);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_diff"}, {24'd0, diff}, 32'd0);
    check({tag, "_bout"}, {31'd0, bout}, 32'd0);
    check({tag, "_zero"}, {31'd0, zero}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; bin = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // 1: basic subtraction with busy window check.
    issue(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("busy_win%0d", i), {31'd0, busy}, (i <= 8) ? 32'd1 : 32'd0);
    end
    wait_drain();

    // 2: underflow wrap, then borrow-in only.
    @(negedge clk);
    issue(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    @(negedge clk); start = 1'b0;
    wait_drain();
    @(negedge clk);
    issue(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    @(negedge clk); start = 1'b0;
    wait_drain();

    // 3: zero result; previous result held while busy.
    @(negedge clk);
    issue(8'h80, 8'h80, 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check("hold_diff", {24'd0, diff}, 32'h0000_00FF);
      check("hold_bout", {31'd0, bout}, 32'd1);
      @(negedge clk);
    end
    wait_drain();

    // Extra: borrow-in with non-zero result.
    @(negedge clk);
    issue(8'h50, 8'h20, 1'b1, 8'h2F, 1'b0, 1'b0);
    @(negedge clk); start = 1'b0;
    wait_drain();

    // 4: start while busy is ignored, operands changing have no effect.
    @(negedge clk);
    issue(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'h00; bin = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_drain();
    repeat (12) @(negedge clk);
    check("no_extra_busy", {31'd0, busy}, 32'd0);

    // 5: reset mid-operation, then a clean operation.
    issue(8'h37, 8'h11, 1'b0, 8'h26, 1'b0, 1'b0);
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    check_idle_zero("midreset");
    repeat (10) @(negedge clk);
    check("after_reset_done", {31'd0, done}, 32'd0);
    issue(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0);
    @(negedge clk); start = 1'b0;
    wait_drain();

    // rst and start together: reset wins.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 8'h44; b = 8'h01;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("rst_start_busy2", {31'd0, busy}, 32'd0);

    // 6: start held high; second operands presented during the done cycle.
    @(negedge clk);
    issue(8'h20, 8'h10, 1'b0, 8'h10, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    #1;
    check("b2b_done_first", {31'd0, done}, 32'd1);
    issue(8'h01, 8'h02, 1'b0, 8'hFF, 1'b1, 1'b0);
    @(negedge clk); start = 1'b0;
    wait_drain();
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
    $fatal(1, "time limit");
  end

endmodule
